ipv4_tx_framer: RTL

IPV4_TX_FRAMER -- requirements
Module: ipv4_tx_framer

---
 rtl/ipv4_pkg.sv | 13 +
 rtl/ipv4_hdr_csum.sv | 17 +
 rtl/ipv4_tx_framer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ipv4_pkg.sv
// ipv4_pkg: shared IPv4 header constants, framer states and a byte-order helper
package ipv4_pkg;
    localparam logic [7:0] IPV4_VER_IHL   = 8'h45;
    localparam int         IPV4_HDR_BYTES = 20;
    localparam logic [7:0] IP_PROTO_TCP   = 8'd6;
    localparam logic [7:0] IP_PROTO_UDP   = 8'd17;

    typedef enum logic [2:0] {ST_IDLE, ST_CSUM, ST_HDR, ST_PAY, ST_DROP} state_t;

    function automatic logic [15:0] bswap16(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction
endpackage

// File: rtl/ipv4_hdr_csum.sv
// ipv4_hdr_csum: combinational one's-complement checksum over ten header words
module ipv4_hdr_csum (
    input  logic [9:0][15:0] words,
    output logic [15:0]      csum
);
    logic [19:0] sum;
    logic [16:0] f1;
    logic [16:0] f2;

    always_comb begin
        sum = '0;
        for (int i = 0; i < 10; i++) sum = sum + {4'b0, words[4'(i)]};
        f1 = {1'b0, sum[15:0]} + {13'b0, sum[19:16]};
        f2 = {1'b0, f1[15:0]} + {16'b0, f1[16]};
        csum = ~f2[15:0];
    end
endmodule

// File: rtl/ipv4_tx_framer.sv
// ipv4_tx_framer: prepends a 20-byte IPv4 header to an L4 payload stream
module ipv4_tx_framer
    import ipv4_pkg::*;
#(
    parameter int          DATA_BYTES  = 4,
    parameter logic [31:0] SRC_ADDR    = 32'h7f000001,
    parameter logic [7:0]  TTL         = 8'd64,
    parameter logic        DONT_FRAG   = 1'b0,
    parameter int          MAX_PAYLOAD = 1480
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    meta_valid,
    output logic                    meta_ready,
    input  logic [15:0]             meta_len,
    input  logic [7:0]              meta_proto,
    input  logic [31:0]             meta_dst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_BYTES*8-1:0] s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_BYTES*8-1:0] m_data,
    output logic                    m_last,
    output logic [DATA_BYTES-1:0]   m_keep,
    output logic                    err_len,
    output logic                    err_oversize,
    output logic [15:0]             ident
);
    localparam int W         = DATA_BYTES * 8;
    localparam int HDR_BEATS = IPV4_HDR_BYTES / DATA_BYTES;
    localparam int BW        = $clog2(HDR_BEATS);
    localparam logic [BW-1:0] LAST_HDR = BW'(HDR_BEATS - 1);

    state_t          state_q, state_d;
    logic [15:0]     len_q, len_d;
    logic [7:0]      proto_q, proto_d;
    logic [31:0]     dst_q, dst_d;
    logic [15:0]     csum_q, csum_d;
    logic [15:0]     ident_q, ident_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [16:0]     pcnt_q, pcnt_d;
    logic            err_len_q, err_len_d;
    logic            err_ovs_q, err_ovs_d;

    logic [9:0][15:0]             words;
    logic [15:0]                  csum_calc;
    logic [HDR_BEATS-1:0][W-1:0]  hdr_beats;
    logic [16:0]                  exp_beats;
    logic [15:0]                  rem;
    logic [DATA_BYTES-1:0]        last_keep;

    ipv4_hdr_csum u_csum (
        .words (words),
        .csum  (csum_calc)
    );

    // Checksum word is zero while summing; the registered value is spliced in on the wire.
    always_comb begin
        words = {dst_q[15:0], dst_q[31:16], SRC_ADDR[15:0], SRC_ADDR[31:16], 16'h0000,
                 {TTL, proto_q}, {1'b0, DONT_FRAG, 14'b0}, ident_q,
                 len_q + 16'(IPV4_HDR_BYTES), {IPV4_VER_IHL, 8'h00}};
        hdr_beats = {bswap16(words[9]), bswap16(words[8]), bswap16(words[7]), bswap16(words[6]),
                     bswap16(csum_q), bswap16(words[4]), bswap16(words[3]), bswap16(words[2]),
                     bswap16(words[1]), bswap16(words[0])};
        exp_beats = ({1'b0, len_q} + 17'(DATA_BYTES - 1)) / 17'(DATA_BYTES);
        rem = len_q % 16'(DATA_BYTES);
        last_keep = (rem == 16'd0) ? '1 : DATA_BYTES'((32'd1 << rem) - 32'd1);
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        proto_d    = proto_q;
        dst_d      = dst_q;
        csum_d     = csum_q;
        ident_d    = ident_q;
        beat_d     = beat_q;
        pcnt_d     = pcnt_q;
        err_len_d  = 1'b0;
        err_ovs_d  = 1'b0;
        meta_ready = 1'b0;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        m_data     = hdr_beats[beat_q];
        m_last     = 1'b0;
        m_keep     = '1;
        case (state_q)
            ST_IDLE: begin
                meta_ready = 1'b1;
                if (meta_valid) begin
                    len_d     = meta_len;
                    proto_d   = meta_proto;
                    dst_d     = meta_dst;
                    beat_d    = '0;
                    pcnt_d    = '0;
                    err_ovs_d = meta_len > 16'(MAX_PAYLOAD);
                    state_d   = err_ovs_d ? ST_DROP : ST_CSUM;
                end
            end
            ST_CSUM: begin
                csum_d  = csum_calc;
                state_d = ST_HDR;
            end
            ST_HDR: begin
                m_valid = 1'b1;
                m_last  = (beat_q == LAST_HDR) && (len_q == 16'd0);
                if (m_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_HDR) begin
                        state_d = m_last ? ST_IDLE : ST_PAY;
                        ident_d = m_last ? ident_q + 16'd1 : ident_q;
                    end
                end
            end
            ST_PAY: begin
                m_valid = s_valid;
                s_ready = m_ready;
                m_data  = s_data;
                m_last  = s_last;
                m_keep  = s_last ? last_keep : '1;
                if (s_valid && m_ready) begin
                    pcnt_d = pcnt_q + 17'd1;
                    if (s_last) begin
                        state_d   = ST_IDLE;
                        ident_d   = ident_q + 16'd1;
                        err_len_d = pcnt_d != exp_beats;
                    end
                end
            end
            ST_DROP: begin
                s_ready = 1'b1;
                if (s_valid && s_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            meta_ready = 1'b0;
            s_ready    = 1'b0;
            m_valid    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            proto_q   <= '0;
            dst_q     <= '0;
            csum_q    <= '0;
            ident_q   <= '0;
            beat_q    <= '0;
            pcnt_q    <= '0;
            err_len_q <= 1'b0;
            err_ovs_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            proto_q   <= proto_d;
            dst_q     <= dst_d;
            csum_q    <= csum_d;
            ident_q   <= ident_d;
            beat_q    <= beat_d;
            pcnt_q    <= pcnt_d;
            err_len_q <= err_len_d;
            err_ovs_q <= err_ovs_d;
        end
    end

    assign err_len      = err_len_q;
    assign err_oversize = err_ovs_q;
    assign ident        = ident_q;
endmodule
